// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: circular capture of retired writeback events with a selectable
// trigger, a post-trigger window and an oldest-first valid/ready drain.
module wb_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic              wb_regwrite,
    input  logic [DATA_W-1:0] wb_pc,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              arm,
    input  logic              clear,
    input  logic [1:0]        trig_mode,
    input  logic [DATA_W-1:0] trig_value,
    input  logic [CNT_W-1:0]  post_count,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_pc,
    output logic [REG_W-1:0]  rd_rd,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              triggered
);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = 2 * DATA_W + REG_W;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] PMAX = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] C1   = CNT_W'(1);
    localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3;

    logic [1:0]        state_q, state_d, mode_q, mode_d;
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d, post_q, post_d;
    logic              overflow_q, overflow_d, triggered_q, triggered_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] tval_q, tval_d;
    logic [EW-1:0]     rd_q, rd_d;
    logic [EW-1:0]     mem [DEPTH];
    logic              cap, hit, xfer, load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mode_q      <= 2'd0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            post_q      <= '0;
            overflow_q  <= 1'b0;
            triggered_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            tval_q      <= '0;
            rd_q        <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            post_q      <= post_d;
            overflow_q  <= overflow_d;
            triggered_q <= triggered_d;
            rd_valid_q  <= rd_valid_d;
            tval_q      <= tval_d;
            rd_q        <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cap)
            mem[wptr_q] <= {wb_pc, wb_rd, wb_data};
    end

    always_comb begin
        state_d = state_q;
        if (clear)
            state_d = IDLE;
        else
            case (state_q)
                IDLE:    state_d = arm ? ARMED : IDLE;
                ARMED:   state_d = hit ? ((post_q == '0) ? DONE : POST) : ARMED;
                POST:    state_d = (wb_valid && post_q == C1) ? DONE : POST;
                default: state_d = (xfer && count_q == C1) ? IDLE : DONE;
            endcase
    end

    always_comb begin
        hit = wb_valid && ((mode_q == 2'd0) ||
                           (mode_q == 2'd1 && wb_pc == tval_q) ||
                           (mode_q == 2'd2 && wb_regwrite && wb_rd == tval_q[REG_W-1:0]));
        cap = wb_valid && !clear && (state_q == ARMED || state_q == POST);
        xfer = state_q == DONE && rd_valid_q && rd_ready;
        wptr_d = wptr_q + PW'(cap);
        count_d = cap ? ((count_q == FULL) ? FULL : count_q + C1) : count_q - (xfer ? C1 : '0);
        overflow_d = overflow_q || (cap && count_q == FULL);
        triggered_d = triggered_q || (state_q == ARMED && hit);
        post_d = (state_q == POST && wb_valid) ? post_q - C1 : post_q;
        mode_d = mode_q;
        tval_d = tval_q;
        if (state_q == IDLE && arm) begin
            mode_d = trig_mode;
            tval_d = trig_value;
            post_d = (post_count > PMAX) ? PMAX : post_count;
            count_d = '0;
            overflow_d = 1'b0;
            triggered_d = 1'b0;
        end
        // Outside DONE the read pointer tracks the oldest entry so it is ready on entry.
        rptr_d = (state_q == DONE) ? rptr_q + PW'(xfer) : wptr_d - PW'(count_d);
        load = state_q == DONE && (!rd_valid_q || xfer) && count_d != '0;
        rd_valid_d = load || (rd_valid_q && !xfer);
        rd_d = load ? mem[rptr_d] : rd_q;
        if (clear) begin
            wptr_d = '0;
            rptr_d = '0;
            count_d = '0;
            overflow_d = 1'b0;
            triggered_d = 1'b0;
            rd_valid_d = 1'b0;
            rd_d = '0;
        end
    end

    always_comb begin
        state     = state_q;
        count     = count_q;
        overflow  = overflow_q;
        triggered = triggered_q;
        rd_valid  = rd_valid_q;
        rd_pc     = rd_q[EW-1 -: DATA_W];
        rd_rd     = rd_q[DATA_W +: REG_W];
        rd_data   = rd_q[DATA_W-1:0];
    end
endmodule
